// File: rtl/trap_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses, cause codes,
// exceptionFlags bit positions and mtvec modes.
package trap_pkg;

   localparam logic [11:0] CsrMstatus  = 12'h300;
   localparam logic [11:0] CsrMie      = 12'h304;
   localparam logic [11:0] CsrMtvec    = 12'h305;
   localparam logic [11:0] CsrMscratch = 12'h340;
   localparam logic [11:0] CsrMepc     = 12'h341;
   localparam logic [11:0] CsrMcause   = 12'h342;
   localparam logic [11:0] CsrMtval    = 12'h343;
   localparam logic [11:0] CsrMip      = 12'h344;

   localparam logic [4:0] ExcInstrMisaligned = 5'd0;
   localparam logic [4:0] ExcInstrFault      = 5'd1;
   localparam logic [4:0] ExcIllegal         = 5'd2;
   localparam logic [4:0] ExcBreakpoint      = 5'd3;
   localparam logic [4:0] ExcLoadMisaligned  = 5'd4;
   localparam logic [4:0] ExcLoadFault       = 5'd5;
   localparam logic [4:0] ExcStoreMisaligned = 5'd6;
   localparam logic [4:0] ExcStoreFault      = 5'd7;
   localparam logic [4:0] ExcEcallM          = 5'd11;

   localparam logic [4:0] IntMsi      = 5'd3;
   localparam logic [4:0] IntMti      = 5'd7;
   localparam logic [4:0] IntMei      = 5'd11;
   localparam int         IntUserBase = 16;

   localparam int FlagFetchBkpt       = 0;
   localparam int FlagFetchFault      = 1;
   localparam int FlagIllegal         = 2;
   localparam int FlagFetchMisaligned = 3;
   localparam int FlagEcall           = 4;
   localparam int FlagEbreak          = 5;
   localparam int FlagDataBkpt        = 6;
   localparam int FlagStoreMisaligned = 7;
   localparam int FlagLoadMisaligned  = 8;
   localparam int FlagStoreFault      = 9;
   localparam int FlagLoadFault       = 10;

   localparam logic [1:0] MtvecDirect   = 2'b00;
   localparam logic [1:0] MtvecVectored = 2'b01;

   function automatic logic [4:0] excCause(input int idx);
      logic [4:0] c;
      case (idx)
         FlagFetchBkpt:       c = ExcBreakpoint;
         FlagFetchFault:      c = ExcInstrFault;
         FlagIllegal:         c = ExcIllegal;
         FlagFetchMisaligned: c = ExcInstrMisaligned;
         FlagEcall:           c = ExcEcallM;
         FlagEbreak:          c = ExcBreakpoint;
         FlagDataBkpt:        c = ExcBreakpoint;
         FlagStoreMisaligned: c = ExcStoreMisaligned;
         FlagLoadMisaligned:  c = ExcLoadMisaligned;
         FlagStoreFault:      c = ExcStoreFault;
         FlagLoadFault:       c = ExcLoadFault;
         default:             c = ExcInstrMisaligned;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/trap_priority_encoder.sv
// Picks the single trap to take: exceptions (flag bit 0 highest) before interrupts,
// interrupts ordered MEI > MSI > MTI > user line 0 > user line 1 > ...
module trap_priority_encoder
   import trap_pkg::*;
(
   input  logic [10:0] flags,
   input  logic [2:0]  machinePending, // {MEI, MTI, MSI}, already gated by mie and MIE
   input  logic [15:0] userPending,
   output logic [4:0]  cause,
   output logic        isInterrupt,
   output logic        isUser,
   output logic [3:0]  userIndex
);

   always_comb begin
      cause       = '0;
      isInterrupt = 1'b0;
      isUser      = 1'b0;
      userIndex   = '0;
      if (|flags) begin
         // Walk from lowest to highest priority so the last hit wins.
         for (int i = 10; i >= 0; i--) begin
            if (flags[i]) cause = excCause(i);
         end
      end else if ((|machinePending) || (|userPending)) begin
         isInterrupt = 1'b1;
         for (int i = 15; i >= 0; i--) begin
            if (userPending[i]) begin
               cause     = 5'(IntUserBase + i);
               userIndex = 4'(i);
               isUser    = 1'b1;
            end
         end
         if (machinePending[1]) begin
            cause  = IntMti;
            isUser = 1'b0;
         end
         if (machinePending[0]) begin
            cause  = IntMsi;
            isUser = 1'b0;
         end
         if (machinePending[2]) begin
            cause  = IntMei;
            isUser = 1'b0;
         end
      end
   end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap/interrupt controller: owns the M-mode trap CSRs, captures user
// interrupt lines and hands a prioritised trap request to the core.
module trap_controller
   import trap_pkg::*;
#(
   parameter int unsigned USER_IRQ_COUNT     = 16,
   parameter logic [15:0] USER_IRQ_EDGE_MASK = 16'h0000,
   parameter logic [31:0] MTVEC_DEFAULT      = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      csrWriteEnable,
   input  logic                      csrReadEnable,
   input  logic [11:0]               csrWriteAddress,
   input  logic [11:0]               csrReadAddress,
   input  logic [31:0]               csrWriteData,
   output logic [31:0]               csrReadData,
   output logic                      requestOutput,
   input  logic [31:0]               programCounter,
   input  logic [31:0]               currentInstruction,
   input  logic [31:0]               instruction_memoryAddress,
   input  logic [31:0]               data_memoryAddress,
   input  logic [10:0]               exceptionFlags,
   input  logic                      isMachineSoftwareInterrupt,
   input  logic                      isMachineTimerInterrupt,
   input  logic                      isMachineExternalInterrupt,
   input  logic [USER_IRQ_COUNT-1:0] userInterrupts,
   output logic                      trapRequest,
   input  logic                      trapAccept,
   input  logic                      trapReturn,
   output logic [31:0]               trapVector,
   output logic [31:0]               trapReturnVector
);

   localparam logic [15:0] LineMask    = 16'((32'd1 << USER_IRQ_COUNT) - 32'd1);
   localparam logic [15:0] EdgeMask    = USER_IRQ_EDGE_MASK & LineMask;
   localparam logic [31:0] MieWritable = {LineMask, 4'b0, 1'b1, 3'b0, 1'b1, 3'b0, 1'b1, 3'b0};

   logic        statusMie, statusMpie;
   logic [31:0] mieReg, mscratch, mepc, mcause, mtval;
   logic [29:0] mtvecBase;
   logic [1:0]  mtvecMode;
   logic [15:0] edgePending, userPrev, edgePendingNext, edgeSet, edgeClear;

   logic [15:0] userLines, mipUser, userPendingMasked;
   logic [31:0] mip, readData, trapValue;
   logic [2:0]  machinePendingMasked;
   logic        readHit, takeTrap;
   logic        wrStatus, wrMie, wrMtvec, wrMscratch, wrMepc, wrMcause, wrMtval, wrMip;
   logic [4:0]  selCause;
   logic        selIsInterrupt, selIsUser;
   logic [3:0]  selUserIndex;

   assign userLines = 16'(userInterrupts);
   assign mipUser   = (userLines & ~EdgeMask) | edgePending;
   assign mip       = {mipUser, 4'b0, isMachineExternalInterrupt, 3'b0,
                       isMachineTimerInterrupt, 3'b0, isMachineSoftwareInterrupt, 3'b0};

   assign machinePendingMasked = {mip[11] & mieReg[11], mip[7] & mieReg[7], mip[3] & mieReg[3]}
                                 & {3{statusMie}};
   assign userPendingMasked    = mipUser & mieReg[31:16] & {16{statusMie}};

   assign trapRequest = (|exceptionFlags) | (|machinePendingMasked) | (|userPendingMasked);
   assign takeTrap    = trapAccept & trapRequest;

   trap_priority_encoder u_encoder (
      .flags         (exceptionFlags),
      .machinePending(machinePendingMasked),
      .userPending   (userPendingMasked),
      .cause         (selCause),
      .isInterrupt   (selIsInterrupt),
      .isUser        (selIsUser),
      .userIndex     (selUserIndex)
   );

   always_comb begin
      trapValue = '0;
      if (!selIsInterrupt) begin
         case (selCause)
            ExcBreakpoint:      trapValue = programCounter;
            ExcInstrMisaligned: trapValue = instruction_memoryAddress;
            ExcIllegal:         trapValue = currentInstruction;
            ExcLoadMisaligned,
            ExcLoadFault,
            ExcStoreMisaligned,
            ExcStoreFault:      trapValue = data_memoryAddress;
            default:            trapValue = '0;
         endcase
      end
   end

   assign trapVector = {mtvecBase, 2'b00} +
                       (((mtvecMode == MtvecVectored) && selIsInterrupt) ?
                        {25'b0, selCause, 2'b00} : 32'b0);
   assign trapReturnVector = {mepc[31:1], 1'b0};

   assign wrStatus   = csrWriteEnable && (csrWriteAddress == CsrMstatus);
   assign wrMie      = csrWriteEnable && (csrWriteAddress == CsrMie);
   assign wrMtvec    = csrWriteEnable && (csrWriteAddress == CsrMtvec);
   assign wrMscratch = csrWriteEnable && (csrWriteAddress == CsrMscratch);
   assign wrMepc     = csrWriteEnable && (csrWriteAddress == CsrMepc);
   assign wrMcause   = csrWriteEnable && (csrWriteAddress == CsrMcause);
   assign wrMtval    = csrWriteEnable && (csrWriteAddress == CsrMtval);
   assign wrMip      = csrWriteEnable && (csrWriteAddress == CsrMip);

   // A new edge overrides any clear landing in the same cycle.
   assign edgeSet         = userLines & ~userPrev & EdgeMask;
   assign edgeClear       = (wrMip ? (~csrWriteData[31:16] & EdgeMask) : 16'h0) |
                            ((takeTrap && selIsUser) ? (16'h1 << selUserIndex) : 16'h0);
   assign edgePendingNext = (edgePending & ~edgeClear) | edgeSet;

   always_comb begin
      readData = '0;
      readHit  = 1'b1;
      case (csrReadAddress)
         CsrMstatus:  readData = {19'b0, 2'b11, 3'b0, statusMpie, 3'b0, statusMie, 3'b0};
         CsrMie:      readData = mieReg;
         CsrMtvec:    readData = {mtvecBase, mtvecMode};
         CsrMscratch: readData = mscratch;
         CsrMepc:     readData = {mepc[31:1], 1'b0};
         CsrMcause:   readData = mcause;
         CsrMtval:    readData = mtval;
         CsrMip:      readData = mip;
         default:     readHit  = 1'b0;
      endcase
   end

   assign requestOutput = csrReadEnable & readHit;
   assign csrReadData   = requestOutput ? readData : 32'b0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         statusMie   <= 1'b0;
         statusMpie  <= 1'b0;
         mieReg      <= '0;
         mtvecBase   <= MTVEC_DEFAULT[31:2];
         mtvecMode   <= MTVEC_DEFAULT[1:0];
         mscratch    <= '0;
         mepc        <= '0;
         mcause      <= '0;
         mtval       <= '0;
         edgePending <= '0;
         userPrev    <= '0;
      end else begin
         userPrev    <= userLines;
         edgePending <= edgePendingNext;
         if (wrMie) mieReg <= csrWriteData & MieWritable;
         if (wrMtvec) begin
            mtvecBase <= csrWriteData[31:2];
            // Modes 2 and 3 are reserved: keep the current mode.
            if (!csrWriteData[1]) mtvecMode <= csrWriteData[1:0];
         end
         if (wrMscratch) mscratch <= csrWriteData;
         if (takeTrap) begin
            mepc       <= {programCounter[31:1], 1'b0};
            mcause     <= {selIsInterrupt, 26'b0, selCause};
            mtval      <= trapValue;
            statusMpie <= statusMie;
            statusMie  <= 1'b0;
         end else begin
            if (trapReturn) begin
               statusMie  <= statusMpie;
               statusMpie <= 1'b1;
            end else if (wrStatus) begin
               statusMie  <= csrWriteData[3];
               statusMpie <= csrWriteData[7];
            end
            if (wrMepc)   mepc   <= {csrWriteData[31:1], 1'b0};
            if (wrMcause) mcause <= csrWriteData;
            if (wrMtval)  mtval  <= csrWriteData;
         end
      end
   end

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller: 4 user lines, line 2 edge-latched, mtvec resets to 0x100.
module tb_trap_controller;

   logic        clk, rst;
   logic        csrWriteEnable, csrReadEnable;
   logic [11:0] csrWriteAddress, csrReadAddress;
   logic [31:0] csrWriteData, csrReadData;
   logic        requestOutput;
   logic [31:0] programCounter, currentInstruction, instruction_memoryAddress, data_memoryAddress;
   logic [10:0] exceptionFlags;
   logic        msip, mtip, meip;
   logic [3:0]  userInterrupts;
   logic        trapRequest, trapAccept, trapReturn;
   logic [31:0] trapVector, trapReturnVector;

   int checks = 0;
   int passes = 0;

   trap_controller #(
      .USER_IRQ_COUNT    (4),
      .USER_IRQ_EDGE_MASK(16'h0004),
      .MTVEC_DEFAULT     (32'h0000_0100)
   ) dut (
      .clk                       (clk),
      .rst                       (rst),
      .csrWriteEnable            (csrWriteEnable),
      .csrReadEnable             (csrReadEnable),
      .csrWriteAddress           (csrWriteAddress),
      .csrReadAddress            (csrReadAddress),
      .csrWriteData              (csrWriteData),
      .csrReadData               (csrReadData),
      .requestOutput             (requestOutput),
      .programCounter            (programCounter),
      .currentInstruction        (currentInstruction),
      .instruction_memoryAddress (instruction_memoryAddress),
      .data_memoryAddress        (data_memoryAddress),
      .exceptionFlags            (exceptionFlags),
      .isMachineSoftwareInterrupt(msip),
      .isMachineTimerInterrupt   (mtip),
      .isMachineExternalInterrupt(meip),
      .userInterrupts            (userInterrupts),
      .trapRequest               (trapRequest),
      .trapAccept                (trapAccept),
      .trapReturn                (trapReturn),
      .trapVector                (trapVector),
      .trapReturnVector          (trapReturnVector)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      csrWriteEnable  = 1'b1;
      csrWriteAddress = a;
      csrWriteData    = d;
      tick();
      csrWriteEnable  = 1'b0;
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      csrReadEnable  = 1'b1;
      csrReadAddress = a;
      #1;
      check(tag, csrReadData, exp);
      csrReadEnable  = 1'b0;
   endtask

   task automatic accept();
      trapAccept = 1'b1;
      tick();
      trapAccept = 1'b0;
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1;
      csrWriteEnable = 1'b0; csrReadEnable = 1'b0;
      csrWriteAddress = '0; csrReadAddress = '0; csrWriteData = '0;
      programCounter = '0; currentInstruction = '0;
      instruction_memoryAddress = '0; data_memoryAddress = '0;
      exceptionFlags = '0; msip = 1'b0; mtip = 1'b0; meip = 1'b0;
      userInterrupts = 4'b0100; trapAccept = 1'b0; trapReturn = 1'b0;

      // Reset values
      #2 rst = 1'b0;
      #1;
      rd("rst_mtvec", 12'h305, 32'h0000_0100);
      rd("rst_mstatus", 12'h300, 32'h0000_1800);
      csrReadEnable = 1'b1; csrReadAddress = 12'h300; #1;
      check("rst_reqout", {31'b0, requestOutput}, 32'h1);
      csrReadAddress = 12'h123; #1;
      check("unowned_data", csrReadData, 32'h0);
      check("unowned_reqout", {31'b0, requestOutput}, 32'h0);
      csrReadEnable = 1'b0;
      check("rst_trapreq", {31'b0, trapRequest}, 32'h0);
      check("rst_retvec", trapReturnVector, 32'h0);

      // Edge line held high through reset latches on the first clock
      @(negedge clk);
      rst = 1'b1;
      tick();
      rd("edge_at_release", 12'h344, 32'h0004_0000);
      userInterrupts = 4'b1100;
      rd("level_mirror", 12'h344, 32'h000C_0000);
      userInterrupts = 4'b0100;
      wr(12'h344, 32'h0);
      rd("edge_cleared", 12'h344, 32'h0);
      userInterrupts = 4'b0000;

      // Timer interrupt, accept, mret
      wr(12'h300, 32'h8);
      wr(12'h304, 32'hFFFF_FFFF);
      rd("mie_mask", 12'h304, 32'h000F_0888);
      wr(12'h304, 32'h80);
      mtip = 1'b1; programCounter = 32'h2000; #1;
      check("mti_req", {31'b0, trapRequest}, 32'h1);
      check("mti_vec_direct", trapVector, 32'h100);
      accept();
      mtip = 1'b0;
      rd("mti_mcause", 12'h342, 32'h8000_0007);
      rd("mti_mepc", 12'h341, 32'h2000);
      rd("mti_mstatus", 12'h300, 32'h1880);
      rd("mti_mtval", 12'h343, 32'h0);
      trapReturn = 1'b1; tick(); trapReturn = 1'b0;
      rd("mret_mstatus", 12'h300, 32'h1888);
      check("retvec", trapReturnVector, 32'h2000);

      // Vectored mtvec, one-cycle pulse on edge line 2
      wr(12'h305, 32'h301);
      rd("mtvec_vect", 12'h305, 32'h301);
      wr(12'h304, 32'h0004_0000);
      userInterrupts = 4'b0100; tick(); userInterrupts = 4'b0000;
      #1;
      check("edge_req", {31'b0, trapRequest}, 32'h1);
      check("edge_vec", trapVector, 32'h348);
      rd("edge_mip", 12'h344, 32'h0004_0000);
      programCounter = 32'h3000;
      accept();
      rd("edge_mip_acc", 12'h344, 32'h0);
      rd("edge_mcause", 12'h342, 32'h8000_0012);
      check("edge_req_after", {31'b0, trapRequest}, 32'h0);

      // Edge set beats a clearing mip write in the same cycle
      userInterrupts = 4'b0100;
      wr(12'h344, 32'h0);
      rd("set_wins", 12'h344, 32'h0004_0000);
      userInterrupts = 4'b0000;
      wr(12'h344, 32'h0);
      rd("set_cleared", 12'h344, 32'h0);

      // Machine interrupt priority seen through the vectored target
      wr(12'h300, 32'h8);
      wr(12'h304, 32'h888);
      meip = 1'b1; msip = 1'b1; mtip = 1'b1; #1;
      check("prio_mei", trapVector, 32'h32C);
      meip = 1'b0; #1;
      check("prio_msi", trapVector, 32'h30C);
      msip = 1'b0; #1;
      check("prio_mti", trapVector, 32'h31C);
      mtip = 1'b0;
      wr(12'h300, 32'h0);

      // Illegal beats load misaligned
      programCounter = 32'h40; currentInstruction = 32'hFFFF_FFFF;
      data_memoryAddress = 32'h55; exceptionFlags = 11'h104; #1;
      check("exc_vec", trapVector, 32'h300);
      accept();
      exceptionFlags = '0;
      rd("ill_mcause", 12'h342, 32'h2);
      rd("ill_mtval", 12'h343, 32'hFFFF_FFFF);
      rd("ill_mepc", 12'h341, 32'h40);

      data_memoryAddress = 32'h1234_5678; exceptionFlags = 11'h400;
      accept();
      rd("ldf_mcause", 12'h342, 32'h5);
      rd("ldf_mtval", 12'h343, 32'h1234_5678);

      instruction_memoryAddress = 32'h777; exceptionFlags = 11'h018;
      accept();
      exceptionFlags = '0;
      rd("mis_mcause", 12'h342, 32'h0);
      rd("mis_mtval", 12'h343, 32'h777);

      // MIE=0 gates interrupts but not exceptions; mepc write dropped on accept
      wr(12'h304, 32'h800);
      meip = 1'b1; #1;
      check("gated_req", {31'b0, trapRequest}, 32'h0);
      rd("gated_mip", 12'h344, 32'h800);
      exceptionFlags = 11'h010; programCounter = 32'h80; #1;
      check("ecall_req", {31'b0, trapRequest}, 32'h1);
      trapAccept = 1'b1;
      wr(12'h341, 32'hDEAD);
      trapAccept = 1'b0;
      rd("ecall_mcause", 12'h342, 32'hB);
      rd("ecall_mepc", 12'h341, 32'h80);
      rd("ecall_mtval", 12'h343, 32'h0);
      trapAccept = 1'b1;
      wr(12'h340, 32'hCAFE);
      trapAccept = 1'b0;
      rd("mscratch_acc", 12'h340, 32'hCAFE);
      meip = 1'b0;

      // Accept beats a simultaneous return
      wr(12'h300, 32'h88);
      trapAccept = 1'b1; trapReturn = 1'b1; tick();
      trapAccept = 1'b0; trapReturn = 1'b0;
      exceptionFlags = '0;
      rd("acc_over_ret", 12'h300, 32'h1880);
      // Accept with nothing pending is ignored
      programCounter = 32'h999;
      accept();
      rd("idle_acc_mstatus", 12'h300, 32'h1880);
      rd("idle_acc_mepc", 12'h341, 32'h80);

      // mtvec WARL and mepc bit0
      wr(12'h305, 32'h1000);
      wr(12'h305, 32'h1003);
      rd("warl_mode0", 12'h305, 32'h1000);
      wr(12'h305, 32'h2001);
      wr(12'h305, 32'h3002);
      rd("warl_mode1", 12'h305, 32'h3001);
      wr(12'h341, 32'h1235);
      rd("mepc_bit0", 12'h341, 32'h1234);

      // Asynchronous reset mid-handler
      #1 rst = 1'b0;
      #1;
      rd("rst2_mscratch", 12'h340, 32'h0);
      rd("rst2_mtvec", 12'h305, 32'h100);
      rd("rst2_mstatus", 12'h300, 32'h1800);
      rd("rst2_mcause", 12'h342, 32'h0);
      rd("rst2_mie", 12'h304, 32'h0);
      check("rst2_retvec", trapReturnVector, 32'h0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
